// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Widths follow the instruction ROM and decode stage.
package fetch_pkg;

    localparam int AW   = 10;
    localparam int IW   = 9;
    localparam int OFFW = 8;
    localparam int CNTW = 16;

    typedef logic [AW-1:0]          addr_t;
    typedef logic [IW-1:0]          instr_t;
    typedef logic signed [OFFW-1:0] off_t;
    typedef logic [CNTW-1:0]        cnt_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED
    } state_t;

    localparam addr_t START_ADDR = '0;

    function automatic cnt_t sat_inc(input cnt_t c);
        return (&c) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Control, ROM and decode-side signals of the fetch controller.
// master is the fetch controller, slave is ROM plus decode.
interface fetch_if;
    import fetch_pkg::*;

    logic   start;
    logic   halt;
    logic   stall;
    logic   branch_taken;
    off_t   branch_off;
    logic   jump_en;
    addr_t  jump_target;
    addr_t  inst_addr;
    instr_t inst_in;
    instr_t ir;
    addr_t  ir_pc;
    logic   ir_valid;
    logic   done;
    cnt_t   fetch_cnt;

    modport master (
        input  start, halt, stall,
        input  branch_taken, branch_off,
        input  jump_en, jump_target,
        input  inst_in,
        output inst_addr, ir, ir_pc,
        output ir_valid, done, fetch_cnt
    );

    modport slave (
        output start, halt, stall,
        output branch_taken, branch_off,
        output jump_en, jump_target,
        output inst_in,
        input  inst_addr, ir, ir_pc,
        input  ir_valid, done, fetch_cnt
    );

endinterface

// File: rtl/fetch_pc_next.sv
// Next-PC selection while running: jump, relative branch or sequential.
// Redirects only count when the IR holds a live instruction.
module fetch_pc_next
    import fetch_pkg::*;
(
    input  addr_t pc,
    input  addr_t ir_pc,
    input  logic  ir_valid,
    input  logic  jump_en,
    input  addr_t jump_target,
    input  logic  branch_taken,
    input  off_t  branch_off,
    output addr_t pc_next,
    output logic  redirect
);

    addr_t off_ext;

    assign off_ext = {{(AW-OFFW){branch_off[OFFW-1]}}, branch_off};

    // Priority: jump over branch over sequential; adds wrap at 2**AW.
    always_comb begin
        pc_next  = pc + 1'b1;
        redirect = 1'b0;
        if (ir_valid && jump_en) begin
            pc_next  = jump_target;
            redirect = 1'b1;
        end else if (ir_valid && branch_taken) begin
            pc_next  = ir_pc + off_ext;
            redirect = 1'b1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC, ROM address, IR capture and run state.
// ROM read is combinational, so the word for pc is captured on the next edge.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter addr_t START_ADDR = fetch_pkg::START_ADDR
)(
    input  logic clk,
    input  logic rst_n,
    fetch_if.master bus
);

    state_t state;
    addr_t  pc;
    addr_t  pc_next;
    logic   redirect;

    assign bus.inst_addr = pc;

    fetch_pc_next u_pc_next (
        .pc           (pc),
        .ir_pc        (bus.ir_pc),
        .ir_valid     (bus.ir_valid),
        .jump_en      (bus.jump_en),
        .jump_target  (bus.jump_target),
        .branch_taken (bus.branch_taken),
        .branch_off   (bus.branch_off),
        .pc_next      (pc_next),
        .redirect     (redirect)
    );

    // Run-state FSM with PC, IR and counter as registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            pc            <= START_ADDR;
            bus.ir        <= '0;
            bus.ir_pc     <= '0;
            bus.ir_valid  <= 1'b0;
            bus.done      <= 1'b0;
            bus.fetch_cnt <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_HALTED: begin
                    bus.ir_valid <= 1'b0;
                    if (bus.start) begin
                        state         <= S_RUN;
                        pc            <= START_ADDR;
                        bus.fetch_cnt <= '0;
                        bus.done      <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (bus.halt) begin
                        state        <= S_HALTED;
                        bus.done     <= 1'b1;
                        bus.ir_valid <= 1'b0;
                    end else if (!bus.stall) begin
                        pc <= pc_next;
                        if (redirect) begin
                            bus.ir_valid <= 1'b0;
                        end else begin
                            bus.ir        <= bus.inst_in;
                            bus.ir_pc     <= pc;
                            bus.ir_valid  <= 1'b1;
                            bus.fetch_cnt <= sat_inc(bus.fetch_cnt);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios, random traffic, saturation.
// Expected values come from a behavioural model of the fetch rules.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fetch_if bus();

    fetch_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    logic [8:0] rom [1024];
    assign bus.inst_in = rom[bus.inst_addr];

    // behavioural model: 0 idle, 1 running, 2 halted
    int m_mode;
    int m_pc;
    int m_ir;
    int m_irpc;
    int m_v;
    int m_done;
    int m_cnt;

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_ir = 0;
        m_irpc = 0; m_v = 0; m_done = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        int off;
        if (m_mode != 1) begin
            m_v = 0;
            if (bus.start) begin
                m_mode = 1; m_pc = 0; m_cnt = 0; m_done = 0;
            end
        end else if (bus.halt) begin
            m_mode = 2; m_done = 1; m_v = 0;
        end else if (bus.stall) begin
            // everything holds
        end else if (m_v == 1 && bus.jump_en) begin
            m_pc = int'(bus.jump_target); m_v = 0;
        end else if (m_v == 1 && bus.branch_taken) begin
            off  = int'(bus.branch_off);
            m_pc = (((m_irpc + off) % 1024) + 1024) % 1024;
            m_v  = 0;
        end else begin
            m_ir   = int'(rom[m_pc]);
            m_irpc = m_pc;
            m_v    = 1;
            m_pc   = (m_pc + 1) % 1024;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".inst_addr"}, 32'(bus.inst_addr), m_pc);
        check({tag, ".ir"},        32'(bus.ir),        m_ir);
        check({tag, ".ir_pc"},     32'(bus.ir_pc),     m_irpc);
        check({tag, ".ir_valid"},  32'(bus.ir_valid),  m_v);
        check({tag, ".done"},      32'(bus.done),      m_done);
        check({tag, ".fetch_cnt"}, 32'(bus.fetch_cnt), m_cnt);
    endtask

    task automatic drive(input logic st, input logic hl, input logic sl,
                         input logic jp, input int jt,
                         input logic br, input int bo);
        bus.start        = st;
        bus.halt         = hl;
        bus.stall        = sl;
        bus.jump_en      = jp;
        bus.jump_target  = addr_t'(jt);
        bus.branch_taken = br;
        bus.branch_off   = off_t'(bo);
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic seq(input string tag);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick(tag);
    endtask

    int saved_cnt;

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 9'($urandom);
        rom[0] = 9'h101; rom[1] = 9'h102;
        rom[2] = 9'h103; rom[3] = 9'h104;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        check_all("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: start and sequential fetch
        drive(1, 0, 0, 0, 0, 0, 0);
        tick("start");
        check("t1.addr0", 32'(bus.inst_addr), 0);
        seq("t1.f0");
        check("t1.ir0", 32'(bus.ir), 32'h101);
        check("t1.irpc0", 32'(bus.ir_pc), 0);
        check("t1.addr1", 32'(bus.inst_addr), 1);
        seq("t1.f1");
        seq("t1.f2");
        seq("t1.f3");
        check("t1.cnt4", 32'(bus.fetch_cnt), 4);
        check("t1.ir3", 32'(bus.ir), 32'h104);

        // 2: relative branches, backwards and wrapping forwards
        seq("t2.f4");
        seq("t2.f5");
        check("t2.irpc5", 32'(bus.ir_pc), 5);
        drive(0, 0, 0, 0, 0, 1, -3);
        tick("t2.br");
        check("t2.pc2", 32'(bus.inst_addr), 2);
        check("t2.bubble", 32'(bus.ir_valid), 0);
        seq("t2.f2");
        check("t2.ir2", 32'(bus.ir), 32'(rom[2]));
        drive(0, 0, 0, 1, 1000, 0, 0);
        tick("t2.j1000");
        seq("t2.f1000");
        check("t2.irpc1000", 32'(bus.ir_pc), 1000);
        drive(0, 0, 0, 0, 0, 1, 127);
        tick("t2.brwrap");
        check("t2.pc103", 32'(bus.inst_addr), 103);
        seq("t2.f103");

        // 3: jump to top of ROM then wrap
        drive(0, 0, 0, 1, 'h3FF, 0, 0);
        tick("t3.j");
        seq("t3.f3ff");
        check("t3.irpc", 32'(bus.ir_pc), 1023);
        check("t3.wrap", 32'(bus.inst_addr), 0);

        // 4: stall holds against a pending jump
        saved_cnt = int'(bus.fetch_cnt);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 1, 'h155, 0, 0);
            tick("t4.stall");
        end
        check("t4.pc", 32'(bus.inst_addr), 0);
        check("t4.irpc", 32'(bus.ir_pc), 1023);
        check("t4.cnt", 32'(bus.fetch_cnt), saved_cnt);
        drive(0, 0, 0, 1, 'h155, 0, 0);
        tick("t4.rel");
        check("t4.jump", 32'(bus.inst_addr), 'h155);

        // 5: halt beats stall, then restart
        seq("t5.f");
        drive(0, 1, 1, 0, 0, 0, 0);
        tick("t5.halt");
        check("t5.done", 32'(bus.done), 1);
        check("t5.v", 32'(bus.ir_valid), 0);
        seq("t5.hold");
        drive(1, 1, 0, 0, 0, 0, 0);
        tick("t5.start");
        check("t5.pc0", 32'(bus.inst_addr), 0);
        check("t5.cnt0", 32'(bus.fetch_cnt), 0);
        check("t5.done0", 32'(bus.done), 0);

        // 6: async reset between edges at pc 37
        seq("t6.f");
        drive(0, 0, 0, 1, 37, 0, 0);
        tick("t6.j37");
        check("t6.pc37", 32'(bus.inst_addr), 37);
        drive(0, 0, 0, 0, 0, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t6.async");
        @(posedge clk); #1;
        check_all("t6.held");
        rst_n = 1'b1;

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 12) == 0, ($urandom % 40) == 0,
                  ($urandom % 4) == 0, ($urandom % 7) == 0,
                  int'($urandom % 1024), ($urandom % 5) == 0,
                  int'($urandom % 256) - 128);
            tick("rand");
        end

        // counter saturation over a long sequential run
        drive(0, 1, 0, 0, 0, 0, 0);
        tick("sat.halt");
        drive(1, 0, 0, 0, 0, 0, 0);
        tick("sat.start");
        for (int i = 0; i < 65540; i++) seq("sat");
        check("sat.cnt", 32'(bus.fetch_cnt), 32'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
